bus_sram_responder: RTL and testbench
=====================================

# bus_sram_responder

Bus slave that answers the burst transactions issued by bus masters such as the camera grabber's frame-buffer writer. It holds a synchronous single-port on-chip SRAM, accepts burst writes into it and serves burst reads from it, so a captured line or frame can be stored and read back by other masters. It sits on the shared wired-OR bus, and every output it does not drive is held at zero.

## Interface
- baseAddress, 32'h50000000, byte address of word 0; aligned to the memory size.
- addressBits, 10, log2 of the number of 32-bit words (default 1024 words, 4 KB).
- clock  in  1  single system clock; all logic on posedge.
- reset  in  1  asynchronous, active-low; low forces every register and output to its reset value immediately.
- beginTransactionIn  in  1  one-cycle start of a transaction; addressDataIn carries the address.
- addressDataIn  in  32  address in the begin cycle, then write data.
- endTransactionIn  in  1  master ends the transaction.
- byteEnablesIn  in  4  byte lanes, sampled in the begin cycle.
- readNotWriteIn  in  1  1 = read, 0 = write; sampled in the begin cycle.
- burstSizeIn  in  8  number of beats minus 1; sampled in the begin cycle.
- dataValidIn  in  1  write-data beat valid.
- addressDataOut  out  32  read data; 0 when not driving.
- dataValidOut  out  1  read-data beat valid.
- endTransactionOut  out  1  one-cycle end marker after the last read beat.
- busyOut  out  1  constant 0; the responder never stalls.
- busErrorOut  out  1  one-cycle error pulse.

## Operation
- Register reset values: all outputs 0, state IDLE, address/count registers 0.
- Address decode uses the address on addressDataIn in the begin cycle.
  - The transaction is "mine" when addr[31:addressBits+2] == baseAddress[31:addressBits+2].
  - A transaction that is not mine is ignored and the state stays IDLE.
- Error conditions, for a mine transaction:
  - addr[1:0] != 0, or
  - the burst overruns the array: word index addr[addressBits+1:2] + burstSize > 2^addressBits - 1. Compute this sum at addressBits+1 bits so the carry is visible.
- State machine:
  - IDLE: on a mine beginTransactionIn, latch the word index, burst count (burstSizeIn), byte enables and direction. Go to ERROR if an error condition holds, else to WRITE or READ_SETUP.
  - WRITE: each cycle with dataValidIn=1 writes addressDataIn to the current index with the latched byte enables, increments the index and decrements the count. The beat that takes the count from 0 moves the state to WAIT_END. Beats beyond the burst are ignored. endTransactionIn in any state except IDLE returns to IDLE.
  - READ_SETUP: present the start index to the RAM, then go to READ.
  - READ: register RAM data onto addressDataOut with dataValidOut=1 every cycle. The index is pre-incremented so beats are back-to-back. After burstSize+1 beats go to END_READ.
  - END_READ: endTransactionOut=1 for one cycle, then IDLE.
  - ERROR: busErrorOut=1 for one cycle, no RAM access, then WAIT_END.
  - WAIT_END: wait for endTransactionIn, then IDLE.
- Byte enables apply to writes only. Reads always return the full word.
- beginTransactionIn while not in IDLE is ignored.
- An endTransactionIn during READ aborts the read: outputs go to 0 next cycle, state returns to IDLE.
- The RAM is not cleared by reset.

## Timing
- Begin sampled at edge E0.
- Read latency:
  - READ_SETUP in the cycle after E0.
  - First dataValidOut in the second cycle after E0.
  - Beat k in cycle 2+k.
  - endTransactionOut in cycle 3+burstSize.
  - IDLE again in cycle 4+burstSize.
- Write: a beat presented in cycle C is stored at the end of C. A read starting at the next begin returns the new data.
- Error: busErrorOut in the cycle after E0.
- Wrap-around: the index never wraps, because overrunning bursts are rejected up front.
- Reset low mid-burst: all outputs become 0 asynchronously. After release the state is IDLE and the next transaction is served normally.

## Test plan
- Reset: hold reset low with random inputs -> all outputs 0; after release and 10 idle cycles, outputs are still 0.
- Single-beat write then read:
  - Write 0x50000010, burstSize 0, BE 0xF, data 0xDEADBEEF.
  - Read the same address -> dataValidOut with 0xDEADBEEF exactly 2 cycles after begin, endTransactionOut 1 cycle later.
- Full burst:
  - Write 16 beats (burstSize 15) at 0x50000000 with data 0..15.
  - Read with burstSize 15 -> 16 consecutive valid beats 0..15, no gaps, then endTransactionOut.
- Byte enables:
  - Write 0xAAAAAAAA with BE 0xF, then 0x11223344 with BE 0x3.
  - Read -> 0xAAAA3344.
- Decode and errors:
  - Begin at 0x60000000 -> no output activity at all.
  - Begin at 0x50000002 -> busErrorOut one cycle, RAM unchanged.
  - Begin at 0x50000FF8 with burstSize 2 -> busErrorOut, no write.
  - In both error cases, IDLE only after endTransactionIn.
- Reset mid-read: pull reset low during beat 5 of a 16-beat read -> outputs 0 that cycle; after release, a fresh read returns correct data.

Source files
------------

// File: rtl/bus_sram_responder.sv
// Burst-capable bus slave around a single-port synchronous SRAM; idle outputs are held at zero for the wired-OR bus.
// Read data appears two cycles after begin, then one beat per cycle; writes store in the cycle they are presented.
// Never stalls: busyOut is tied low, and beats beyond a burst are dropped.
module bus_sram_responder #(
  parameter logic [31:0] baseAddress = 32'h5000_0000,
  parameter int          addressBits = 10
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        beginTransactionIn,
  input  logic [31:0] addressDataIn,
  input  logic        endTransactionIn,
  input  logic [3:0]  byteEnablesIn,
  input  logic        readNotWriteIn,
  input  logic [7:0]  burstSizeIn,
  input  logic        dataValidIn,
  output logic [31:0] addressDataOut,
  output logic        dataValidOut,
  output logic        endTransactionOut,
  output logic        busyOut,
  output logic        busErrorOut
);

  // One spare bit above the wider operand keeps the overrun carry visible.
  localparam int sumBits = ((addressBits > 8) ? addressBits : 8) + 1;
  localparam logic [sumBits-1:0] lastIndex = sumBits'((64'd1 << addressBits) - 64'd1);
  localparam logic [addressBits-1:0] oneIndex = addressBits'(1);
  localparam int words = 1 << addressBits;

  typedef enum logic [2:0] {
    stIdle, stWrite, stReadSetup, stRead, stEndRead, stError, stWaitEnd
  } stateT;

  stateT state, nextState;

  logic [addressBits-1:0] wordIndex;
  logic [7:0]             beatCount;
  logic [3:0]             byteEnables;
  logic [31:0]            ramQ;
  logic [31:0]            mem [0:words-1];

  logic                   isMine, misaligned, overrun;
  logic                   startAccepted, writeBeat, readBeat;
  logic [sumBits-1:0]     lastBeatIndex;

  assign isMine        = addressDataIn[31:addressBits+2] == baseAddress[31:addressBits+2];
  assign misaligned    = addressDataIn[1:0] != 2'b00;
  assign lastBeatIndex = sumBits'(addressDataIn[addressBits+1:2]) + sumBits'(burstSizeIn);
  assign overrun       = lastBeatIndex > lastIndex;

  assign startAccepted = (state == stIdle) && beginTransactionIn && isMine;
  assign writeBeat     = (state == stWrite) && dataValidIn;
  assign readBeat      = (state == stReadSetup) || (state == stRead);

  assign busyOut        = 1'b0;
  assign addressDataOut = dataValidOut ? ramQ : 32'h0;

  always_comb begin
    nextState         = state;
    dataValidOut      = 1'b0;
    endTransactionOut = 1'b0;
    busErrorOut       = 1'b0;
    case (state)
      stIdle: begin
        if (beginTransactionIn && isMine) begin
          if (misaligned || overrun) nextState = stError;
          else if (readNotWriteIn)   nextState = stReadSetup;
          else                       nextState = stWrite;
        end
      end
      stWrite:     if (dataValidIn && beatCount == 8'd0) nextState = stWaitEnd;
      stReadSetup: nextState = stRead;
      stRead: begin
        dataValidOut = 1'b1;
        if (beatCount == 8'd0) nextState = stEndRead;
      end
      stEndRead: begin
        endTransactionOut = 1'b1;
        nextState         = stIdle;
      end
      stError: begin
        busErrorOut = 1'b1;
        nextState   = stWaitEnd;
      end
      stWaitEnd:   nextState = stWaitEnd;
      default:     nextState = stIdle;
    endcase
    // The master may end (or abort) a transaction from any active state.
    if (state != stIdle && endTransactionIn) nextState = stIdle;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= stIdle;
      wordIndex   <= '0;
      beatCount   <= '0;
      byteEnables <= '0;
    end else begin
      state <= nextState;
      if (startAccepted) begin
        wordIndex   <= addressDataIn[addressBits+1:2];
        beatCount   <= burstSizeIn;
        byteEnables <= byteEnablesIn;
      end else if (writeBeat || readBeat) begin
        // Read index runs one ahead so the RAM output is ready every cycle.
        wordIndex <= wordIndex + oneIndex;
        if (state != stReadSetup) beatCount <= beatCount - 8'd1;
      end
    end
  end

  always_ff @(posedge clock) begin
    for (int b = 0; b < 4; b++) begin
      if (writeBeat && byteEnables[b]) mem[wordIndex][8*b +: 8] <= addressDataIn[8*b +: 8];
    end
    if (readBeat) ramQ <= mem[wordIndex];
  end

endmodule

// File: tb/tb_bus_sram_responder.sv
// Bench for bus_sram_responder: directed vector table, hand-written reset/boundary sequences,
// and random transactions checked against a word-array model of the memory.
module tb_bus_sram_responder;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        beginTransactionIn = 1'b0;
  logic [31:0] addressDataIn = '0;
  logic        endTransactionIn = 1'b0;
  logic [3:0]  byteEnablesIn = '0;
  logic        readNotWriteIn = 1'b0;
  logic [7:0]  burstSizeIn = '0;
  logic        dataValidIn = 1'b0;
  logic [31:0] addressDataOut;
  logic        dataValidOut, endTransactionOut, busyOut, busErrorOut;

  bus_sram_responder #(.baseAddress(32'h5000_0000), .addressBits(10)) dut (
    .clock(clock), .reset(reset),
    .beginTransactionIn(beginTransactionIn), .addressDataIn(addressDataIn),
    .endTransactionIn(endTransactionIn), .byteEnablesIn(byteEnablesIn),
    .readNotWriteIn(readNotWriteIn), .burstSizeIn(burstSizeIn), .dataValidIn(dataValidIn),
    .addressDataOut(addressDataOut), .dataValidOut(dataValidOut),
    .endTransactionOut(endTransactionOut), .busyOut(busyOut), .busErrorOut(busErrorOut)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Memory model: word contents plus per-byte "has been written" flags.
  logic [31:0] refMem   [0:1023];
  logic [3:0]  refKnown [0:1023];

  int          txnCycle;
  logic        sawErr, sawVld;
  logic [31:0] firstData;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  be;
    logic        rnw;
    logic [7:0]  burst;
    logic [31:0] data;
    logic        expErr;
    logic        expVld;
    logic [31:0] expFirst;
  } vecT;

  vecT vecs [15];

  task automatic tick();
    @(posedge clock);
    #1;
    txnCycle++;
    if (txnCycle == 1) sawErr = busErrorOut;
    if (txnCycle == 2) begin
      sawVld    = dataValidOut;
      firstData = addressDataOut;
    end
  endtask

  task automatic checkOut(input string name, input logic eVld, input logic eEnd, input logic eErr,
                          input logic [31:0] eData, input logic [31:0] mask);
    checks++;
    if ({dataValidOut, endTransactionOut, busErrorOut, busyOut} !== {eVld, eEnd, eErr, 1'b0} ||
        (addressDataOut & mask) !== (eData & mask)) begin
      errors++;
      $display("FAIL %s: got vld=%b end=%b err=%b busy=%b data=%h, want vld=%b end=%b err=%b busy=0 data=%h mask=%h",
               name, dataValidOut, endTransactionOut, busErrorOut, busyOut, addressDataOut,
               eVld, eEnd, eErr, eData, mask);
    end
  endtask

  task automatic checkQuiet(input string name);
    checkOut(name, 1'b0, 1'b0, 1'b0, 32'h0, 32'hFFFF_FFFF);
  endtask

  task automatic checkVal(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h, want %h", name, got, want);
    end
  endtask

  function automatic logic [31:0] knownMask(input int i);
    logic [31:0] m;
    for (int b = 0; b < 4; b++) m[8*b +: 8] = {8{refKnown[i][b]}};
    return m;
  endfunction

  task automatic idleInputs();
    beginTransactionIn = 1'b0;
    endTransactionIn   = 1'b0;
    dataValidIn        = 1'b0;
    addressDataIn      = $urandom;
  endtask

  // One complete transaction; expectations come from the decode rules and the memory model.
  task automatic doTxn(input logic [31:0] addr, input logic [3:0] be, input logic rnw,
                       input logic [7:0] burst, input logic [31:0] dbase);
    int  idx;
    bit  mine, err;
    int  beats;
    idx  = int'(addr[11:2]);
    mine = (addr[31:12] == 20'h50000);
    err  = mine && (addr[1:0] != 2'b00 || idx + int'(burst) > 1023);
    txnCycle = 0; sawErr = 1'b0; sawVld = 1'b0; firstData = 32'h0;
    beginTransactionIn = 1'b1; addressDataIn = addr; byteEnablesIn = be;
    readNotWriteIn = rnw; burstSizeIn = burst; dataValidIn = 1'b0; endTransactionIn = 1'b0;
    tick();
    idleInputs();
    if (!mine) begin
      for (int c = 0; c < int'(burst) + 4; c++) begin
        checkQuiet("foreign");
        dataValidIn      = !rnw;
        addressDataIn    = dbase + c;
        endTransactionIn = (c == int'(burst) + 3);
        tick();
      end
      idleInputs();
      checkQuiet("foreign after");
    end else if (err) begin
      checkOut("error pulse", 1'b0, 1'b0, 1'b1, 32'h0, 32'hFFFF_FFFF);
      for (int c = 0; c < 5; c++) begin
        if (c > 0) checkQuiet("error wait");
        dataValidIn   = !rnw;
        addressDataIn = dbase + c;
        if (c == 1) begin
          // A valid read begin here must be ignored: the slave is still waiting for end.
          beginTransactionIn = 1'b1; addressDataIn = 32'h5000_0010;
          readNotWriteIn = 1'b1; burstSizeIn = 8'd0;
        end else begin
          beginTransactionIn = 1'b0;
        end
        tick();
      end
      idleInputs();
      checkQuiet("error pre-end");
      endTransactionIn = 1'b1;
      tick();
      idleInputs();
      checkQuiet("error ended");
    end else if (!rnw) begin
      beats = 0;
      for (int c = 0; beats <= int'(burst); c++) begin
        checkQuiet("write quiet");
        dataValidIn   = ($urandom_range(0, 3) != 0) || (c > 40);
        addressDataIn = dataValidIn ? dbase + beats : $urandom;
        if (dataValidIn) begin
          for (int b = 0; b < 4; b++) if (be[b]) begin
            refMem[idx+beats][8*b +: 8] = addressDataIn[8*b +: 8];
            refKnown[idx+beats][b]      = 1'b1;
          end
          beats++;
        end
        tick();
      end
      // Extra beat past the burst must not reach the memory.
      dataValidIn = 1'b1; addressDataIn = ~dbase;
      checkQuiet("write extra");
      tick();
      idleInputs();
      endTransactionIn = 1'b1;
      tick();
      idleInputs();
      checkQuiet("write ended");
    end else begin
      checkQuiet("read setup");
      tick();
      for (int k = 0; k <= int'(burst); k++) begin
        checkOut("read beat", 1'b1, 1'b0, 1'b0, refMem[idx+k], knownMask(idx+k));
        tick();
      end
      checkOut("read end", 1'b0, 1'b1, 1'b0, 32'h0, 32'hFFFF_FFFF);
      tick();
      checkQuiet("read idle");
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) begin
      refKnown[i] = 4'h0;
      refMem[i]   = 32'h0;
    end

    // Reset held low with random inputs: everything stays at zero.
    for (int c = 0; c < 8; c++) begin
      beginTransactionIn = $urandom; addressDataIn = 32'h5000_0000 | ($urandom & 32'hFFC);
      endTransactionIn = $urandom; byteEnablesIn = $urandom; readNotWriteIn = $urandom;
      burstSizeIn = $urandom; dataValidIn = $urandom;
      @(posedge clock); #1;
      checkQuiet("in reset");
    end
    idleInputs();
    @(negedge clock);
    reset = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      checkQuiet("after reset");
    end

    //          addr          be    rnw   burst  data          err   vld   first
    vecs[0]  = '{32'h5000_0010, 4'hF, 1'b0, 8'd0, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0};
    vecs[1]  = '{32'h5000_0010, 4'hF, 1'b1, 8'd0, 32'h0,         1'b0, 1'b1, 32'hDEAD_BEEF};
    vecs[2]  = '{32'h5000_0020, 4'hF, 1'b0, 8'd0, 32'hAAAA_AAAA, 1'b0, 1'b0, 32'h0};
    vecs[3]  = '{32'h5000_0020, 4'h3, 1'b0, 8'd0, 32'h1122_3344, 1'b0, 1'b0, 32'h0};
    vecs[4]  = '{32'h5000_0020, 4'hF, 1'b1, 8'd0, 32'h0,         1'b0, 1'b1, 32'hAAAA_3344};
    vecs[5]  = '{32'h6000_0010, 4'hF, 1'b0, 8'd0, 32'h1234_5678, 1'b0, 1'b0, 32'h0};
    vecs[6]  = '{32'h6000_0010, 4'hF, 1'b1, 8'd0, 32'h0,         1'b0, 1'b0, 32'h0};
    vecs[7]  = '{32'h5000_0002, 4'hF, 1'b1, 8'd0, 32'h0,         1'b1, 1'b0, 32'h0};
    vecs[8]  = '{32'h5000_0FF8, 4'hF, 1'b0, 8'd0, 32'h7777_7777, 1'b0, 1'b0, 32'h0};
    vecs[9]  = '{32'h5000_0FF8, 4'hF, 1'b0, 8'd2, 32'h0BAD_C0DE, 1'b1, 1'b0, 32'h0};
    vecs[10] = '{32'h5000_0FF8, 4'hF, 1'b1, 8'd0, 32'h0,         1'b0, 1'b1, 32'h7777_7777};
    vecs[11] = '{32'h5000_0012, 4'hF, 1'b0, 8'd0, 32'h5555_5555, 1'b1, 1'b0, 32'h0};
    vecs[12] = '{32'h5000_0010, 4'hF, 1'b1, 8'd0, 32'h0,         1'b0, 1'b1, 32'hDEAD_BEEF};
    vecs[13] = '{32'h5000_0FF8, 4'hF, 1'b0, 8'd1, 32'hCAFE_0000, 1'b0, 1'b0, 32'h0};
    vecs[14] = '{32'h5000_0FFC, 4'hF, 1'b1, 8'd0, 32'h0,         1'b0, 1'b1, 32'hCAFE_0001};

    for (int v = 0; v < 15; v++) begin
      doTxn(vecs[v].addr, vecs[v].be, vecs[v].rnw, vecs[v].burst, vecs[v].data);
      checkVal($sformatf("vec%0d err", v), {31'h0, sawErr}, {31'h0, vecs[v].expErr});
      checkVal($sformatf("vec%0d vld", v), {31'h0, sawVld}, {31'h0, vecs[v].expVld});
      checkVal($sformatf("vec%0d data", v), firstData, vecs[v].expFirst);
    end

    // Full 16-beat burst written with 0..15 and read back gap-free.
    doTxn(32'h5000_0000, 4'hF, 1'b0, 8'd15, 32'h0);
    doTxn(32'h5000_0000, 4'hF, 1'b1, 8'd15, 32'h0);
    checkVal("burst first", firstData, 32'h0);

    // Reset pulled low during beat 5 of a 16-beat read.
    txnCycle = 0;
    beginTransactionIn = 1'b1; addressDataIn = 32'h5000_0000;
    readNotWriteIn = 1'b1; burstSizeIn = 8'd15;
    tick();
    idleInputs();
    for (int c = 0; c < 6; c++) tick();
    checkOut("beat5 before reset", 1'b1, 1'b0, 1'b0, 32'h5, 32'hFFFF_FFFF);
    reset = 1'b0;
    #1;
    checkQuiet("async reset mid-read");
    @(posedge clock); #1;
    checkQuiet("held reset");
    @(negedge clock);
    reset = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      checkQuiet("post reset idle");
    end
    doTxn(32'h5000_0000, 4'hF, 1'b1, 8'd15, 32'h0);
    checkVal("post reset read", firstData, 32'h0);

    // Random transactions, biased toward the low words and the top-of-array boundary.
    for (int t = 0; t < 60; t++) begin
      logic [31:0] addr;
      logic [7:0]  burst;
      int          sel;
      sel = $urandom_range(0, 9);
      if (sel == 0) begin
        addr = $urandom;
        if (addr[31:12] == 20'h50000) addr[31] = 1'b1;
        burst = 8'($urandom_range(0, 6));
      end else if (sel < 6) begin
        addr  = {20'h50000, 10'($urandom_range(0, 40)), 2'b00};
        burst = 8'($urandom_range(0, 15));
      end else begin
        addr  = {20'h50000, 10'($urandom_range(1005, 1023)), 2'b00};
        burst = 8'($urandom_range(0, 24));
      end
      if ($urandom_range(0, 9) == 0) addr[1:0] = 2'($urandom_range(1, 3));
      doTxn(addr, 4'($urandom), 1'($urandom), burst, $urandom);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
